z80_mem_arbiter: RTL
====================

# z80_mem_arbiter

Round-robin bus controller that shares the single-ported Z80 behavioural memory between `N` requesters (port 0 = Z80 core bus adapter, port 1 = trace/BIOS loader or debug DMA). It sequences every access into the memory's strobe protocol: active-low `MREQ_L`/`RD_L`/`WR_L`, read data returned one clock after the strobes are sampled, and write data held through the commit edge. It returns read data and a one-cycle `done` per access. It sits between the requesters and the memory instance in the testbench top; the top-level tristate glue drives the memory's `data_bus`.

## Interface
Parameters:
- `N`, 2, number of requesters; port 0 has highest priority out of reset.
- `MEM_DEPTH`, 200, number of implemented memory bytes; addresses `>= MEM_DEPTH` fault.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester access request; held high until matching `done`.
- `we`  in  N  per-requester write (1) or read (0); sampled at grant.
- `addr`  in  N×16  per-requester byte address; sampled at grant.
- `wdata`  in  N×8  per-requester write data; sampled at grant.
- `grant`  out  N  one-hot owner of the in-flight access; 0 when idle.
- `done`  out  N  one-cycle completion pulse to the owner.
- `err`  out  1  valid with `done`; 1 = address out of range.
- `rdata`  out  8  read data; valid with `done` on a read; holds its value otherwise.
- `mem_mreq_L`, `mem_rd_L`, `mem_wr_L`  out  1 each  memory strobes, registered.
- `mem_addr`  out  16  memory address, registered.
- `mem_wdata`  out  8  write data toward `data_bus`.
- `mem_wdata_oe`  out  1  top-level enable that drives `mem_wdata` onto `data_bus`.
- `mem_rdata`  in  8  `data_bus` as seen by the arbiter.

## Operation
- FSM states: IDLE, STROBE, HOLD.
- IDLE: if any `req` bit is high, pick a winner, latch its `we`, `addr` and `wdata`, set `grant`, and go to STROBE. Otherwise stay in IDLE.
- Arbitration is round-robin. Search starts at `last+1` (mod N); `last` is the index of the most recently granted port. Reset sets `last = N-1`, so port 0 wins first.
- STROBE:
  - Read: `mem_mreq_L = 0` and `mem_rd_L = 0`.
  - Write: `mem_mreq_L = 0` and `mem_wr_L = 0`, with `mem_wdata_oe = 1`.
  - Always go to HOLD next.
- HOLD: all strobes high. On a write, `mem_wdata_oe` stays 1 so the memory captures the data at the edge that ends HOLD. Go to IDLE next.
- Leaving HOLD:
  - Pulse `done[owner]` for one cycle.
  - On a read, load `rdata` from `mem_rdata` at that edge.
  - Set `grant` to 0 and update `last`.
- Out-of-range address (`addr >= MEM_DEPTH`), detected at grant:
  - No strobe is asserted; the access walks the same STROBE and HOLD timing.
  - `done` fires with `err = 1`.
  - `rdata = 8'hFF` for a read; a write is dropped.
- Dropping `req` mid-access does not abort the access; `done` still fires. A new `req` arriving mid-access waits for IDLE.
- `addr`, `we` and `wdata` changing after grant are ignored.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `mem_mreq_L`, `mem_rd_L` and `mem_wr_L` = 1.
  - `mem_wdata_oe`, `grant`, `done` and `err` = 0.
  - `rdata` = 8'h00, `mem_addr` = 0, `mem_wdata` = 0.
  - `last` = N-1.
- Reset mid-access aborts the access: strobes are released at once and no `done` is issued.
- Let E0 be the edge at which `req` is sampled in IDLE.
  - Strobes are low during E0..E1.
  - Memory read data appears after E1.
  - `rdata` and `done` are valid during E2..E3.
- Latency from `req` sampled to `done` is 3 cycles. Peak throughput is one access per 3 cycles.
- The cycle in which `done` is high is an IDLE cycle. A `req` present then, including a new request from the same port, is granted at its ending edge.
- `mem_addr` is stable from E0 through E2. `mem_wdata` is stable while `mem_wdata_oe` = 1.
- Strobes never go low on consecutive accesses without at least 2 high cycles between them.

## Test plan
- Single read, port 0, `addr` = 16'h0005, memory byte = 8'hA5 → strobes low exactly one cycle; `done[0]` at E2..E3 with `rdata` = 8'hA5 and `err` = 0.
- Write then read, port 1, `addr` = 16'h0010, `wdata` = 8'h3C → `mem_wr_L` low one cycle, `oe` high for 2 cycles; the following read returns 8'h3C.
- Both ports request continuously, as reads → grants alternate 0,1,0,1 starting with port 0; each `done` is 3 cycles apart.
- Out-of-range read at 16'h00C8 with `MEM_DEPTH` = 200 → no strobe asserted; `done` with `err` = 1 and `rdata` = 8'hFF. Out-of-range write → memory unchanged.
- Port 0 drops `req` in STROBE → access completes and `done[0]` still pulses; port 1 pending is granted in the `done` cycle's ending edge.
- Assert `rst` during STROBE of a write → strobes and `oe` high/0 immediately with no `done`; after release, port 0 wins first.

Source files
------------

// File: rtl/z80_mem_arbiter_if.sv
// Requester/memory bus bundle for z80_mem_arbiter: per-port request side plus
// the registered strobe/address/data side toward the Z80 behavioural memory.
interface z80_mem_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]       req;
  logic [N-1:0]       we;
  logic [N-1:0][15:0] addr;
  logic [N-1:0][7:0]  wdata;
  logic [N-1:0]       grant;
  logic [N-1:0]       done;
  logic               err;
  logic [7:0]         rdata;

  logic               mem_mreq_L;
  logic               mem_rd_L;
  logic               mem_wr_L;
  logic [15:0]        mem_addr;
  logic [7:0]         mem_wdata;
  logic               mem_wdata_oe;
  logic [7:0]         mem_rdata;

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  grant, done, err, rdata,
    input  mem_mreq_L, mem_rd_L, mem_wr_L, mem_addr, mem_wdata, mem_wdata_oe
  );

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output grant, done, err, rdata,
    output mem_mreq_L, mem_rd_L, mem_wr_L, mem_addr, mem_wdata, mem_wdata_oe
  );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Round-robin arbiter sequencing N requesters onto the single-ported Z80 memory
// strobe protocol: IDLE -> STROBE (strobes low) -> HOLD (commit edge) -> IDLE.
module z80_mem_arbiter #(
  parameter int N         = 2,
  parameter int MEM_DEPTH = 200
) (
  input logic              clk,
  input logic              rst,
  z80_mem_arbiter_if.slave bus
);

  localparam int          IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
  localparam logic [N-1:0] ONE  = N'(1);

  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic          is_write;
  logic          is_err;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          pick_oor;
  int            cand;

  // Search starts just after the last granted port so every requester gets a turn.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!pick_valid && bus.req[IW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
    pick_oor = {1'b0, bus.addr[pick_idx]} >= DEPTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last             <= IW'(N - 1);
      owner            <= '0;
      is_write         <= 1'b0;
      is_err           <= 1'b0;
      bus.grant        <= '0;
      bus.done         <= '0;
      bus.err          <= 1'b0;
      bus.rdata        <= 8'h00;
      bus.mem_mreq_L   <= 1'b1;
      bus.mem_rd_L     <= 1'b1;
      bus.mem_wr_L     <= 1'b1;
      bus.mem_addr     <= 16'h0000;
      bus.mem_wdata    <= 8'h00;
      bus.mem_wdata_oe <= 1'b0;
    end else begin
      bus.done <= '0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner         <= pick_idx;
            is_write      <= bus.we[pick_idx];
            is_err        <= pick_oor;
            bus.grant     <= ONE << pick_idx;
            bus.mem_addr  <= bus.addr[pick_idx];
            bus.mem_wdata <= bus.wdata[pick_idx];
            // Out-of-range accesses keep the timing but never touch the memory.
            if (!pick_oor) begin
              bus.mem_mreq_L <= 1'b0;
              if (bus.we[pick_idx]) begin
                bus.mem_wr_L     <= 1'b0;
                bus.mem_wdata_oe <= 1'b1;
              end else begin
                bus.mem_rd_L <= 1'b0;
              end
            end
            state <= STROBE;
          end
        end
        STROBE: begin
          bus.mem_mreq_L <= 1'b1;
          bus.mem_rd_L   <= 1'b1;
          bus.mem_wr_L   <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          bus.done         <= bus.grant;
          bus.err          <= is_err;
          bus.mem_wdata_oe <= 1'b0;
          bus.grant        <= '0;
          last             <= owner;
          if (!is_write) begin
            bus.rdata <= is_err ? 8'hFF : bus.mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
